frogger_lane_engine: RTL and testbench
======================================

// Module: frogger_lane_engine
// PURPOSE
//  Playfield responder for frogger_ctrl: owns the scrolling lane state (logs, cars, lily pads).
//  Answers tile lookups for the frog position (bitmap/on-log/collided) and for the VGA renderer.
//  Emits a log-shift strobe so the frog rides logs in lockstep with the scenery.
//  Sits between the game top level, frogger_ctrl and the tile renderer.
// PARAMETERS
//  c_GRID_W    14         columns 0..13
//  c_GRID_H    15         rows 0..14; row 0 home, 1-5 river, 6 median, 7-12 road, 13-14 start
//  c_TICK_DIV  6_250_000  base clocks per lane-step unit
// PORTS
//  i_Clk           in   1  system clock
//  i_Rst_n         in   1  async active-low reset
//  i_Game_Active   in   1  1 = lanes scroll; 0 = freeze (lookups still answered)
//  i_Reload        in   1  1-cycle pulse: reload lane patterns, clear dividers
//  i_Frogger_X     in   6  frog column
//  i_Frogger_Y     in   6  frog row
//  i_Col_Count_Div in   6  renderer column
//  i_Row_Count_Div in   6  renderer row
//  o_Bitmap_Data   out  4  tile code under the frog
//  o_On_Log        out  1  frog row is river and tile = LOG
//  o_Collided      out  1  frog row is road and tile = CAR
//  o_Render_Tile   out  4  tile code at renderer coordinate
//  o_Log_Shift     out  1  1-cycle strobe, frog's river lane stepped left
// BEHAVIOUR
//  Reset is async on i_Rst_n low, synchronous release. All outputs reset to 0.
//  Reset loads patterns from package constants and clears all dividers.
//  Tile codes: 0 OUT, 1 GRASS, 2 WATER, 3 LOG, 4 LILY, 5 ROAD, 6 CAR.
//  Row 0 is fixed: LILY at columns 1,4,7,10,13 and GRASS elsewhere.
//  Rows 6, 13 and 14 are GRASS.
//  Moving lanes (rows 1-5, 7-12) each hold a c_GRID_W-bit occupancy register.
//   - River: bit=1 -> LOG, else WATER.
//   - Road: bit=1 -> CAR, else ROAD.
//  Each moving lane has its own divider, period c_TICK_DIV*k, where k in 1..4 comes from the package per lane.
//  At terminal count, the lane rotates by one column and the divider returns to 0.
//  Wrap-around: rotation is circular (col 0 <-> col 13), so the pattern is never lost.
//  Direction: all river lanes rotate left (col c takes col c+1, col 0 takes col 13).
//  Road lanes alternate direction: even rows left, odd rows right.
//  i_Game_Active=0: dividers and patterns hold; lookups are still served.
//  i_Reload: has priority over a step in the same cycle. Patterns go to reset constants, dividers go to 0. No strobe is emitted.
//  Lookup latency is exactly 1 cycle and both ports are independent.
//   - Outputs registered at cycle N+1 reflect inputs and pattern state sampled at edge N.
//   - Same-cycle step: the lookup sees the pre-rotation pattern.
//  Out of range (X>=c_GRID_W or Y>=c_GRID_H): tile=0, o_On_Log=0, o_Collided=0, for either port.
//  o_Collided and o_On_Log are registered levels, valid every cycle, and are never both 1.
//  o_Log_Shift is registered with the same cycle alignment as the lookup.
//   - It asserts 1 cycle after the step of river lane i_Frogger_Y when that row is 1..5.
//   - frogger_ctrl decrements X on this strobe and wraps 0 -> c_GRID_W-1, matching the rotation.
// STRUCTURE
//  frogger_pkg holds:
//   - tile code localparams, grid dimensions;
//   - per-row lane type (fixed/river/road), speed factor k, direction, initial pattern;
//   - lily-pad column mask.
//  Sub-module lane_shifter (one per moving lane) holds:
//   - parameters WIDTH, DIV, DIR, INIT;
//   - the divider and the rotate register;
//   - outputs o_Pattern[WIDTH-1:0] and o_Step.
//  Top level generates 11 lane_shifter instances, two row/col mux lookup paths, and output registers.
// TESTING
//  1. Reset low mid-step -> all outputs 0 immediately. After release, row 1 equals its INIT pattern and the divider restarts from 0.
//  2. X=4,Y=0 -> o_Bitmap_Data=4 one cycle later. X=5,Y=0 -> 1.
//  3. Frog on row 2 with a LOG at col 0 -> o_On_Log=1. After one left step, col 13 reads LOG (wrap). o_Log_Shift pulses once, 1 cycle after the step.
//  4. Car moving into frog column on row 8 -> o_Collided=1 on the cycle after the rotation, not before.
//  5. i_Game_Active=0 for 3*c_TICK_DIV clocks -> every pattern unchanged and no strobes. On resume, the first step arrives after the remaining divider count.
//  6. i_Reload on the same cycle as a step -> patterns equal INIT and no o_Log_Shift. X=14 or Y=15 -> tile 0 on both ports.

Source files
------------

// File: rtl/frogger_pkg.sv
// rtl/frogger_pkg.sv - playfield constants, tile codes and per-lane configuration
package frogger_pkg;

    localparam int C_GRID_W   = 14;
    localparam int C_GRID_H   = 15;
    localparam int C_TICK_DIV = 6_250_000;

    localparam logic [3:0] TILE_OUT   = 4'd0;
    localparam logic [3:0] TILE_GRASS = 4'd1;
    localparam logic [3:0] TILE_WATER = 4'd2;
    localparam logic [3:0] TILE_LOG   = 4'd3;
    localparam logic [3:0] TILE_LILY  = 4'd4;
    localparam logic [3:0] TILE_ROAD  = 4'd5;
    localparam logic [3:0] TILE_CAR   = 4'd6;

    // Lily pads sit at columns 1, 4, 7, 10 and 13 of the home row.
    localparam logic [C_GRID_W-1:0] C_LILY_MASK = 14'h2492;

    typedef enum logic [1:0] {
        LANE_FIXED = 2'd0,
        LANE_RIVER = 2'd1,
        LANE_ROAD  = 2'd2
    } lane_kind_e;

    function automatic lane_kind_e lane_kind(int row);
        if (row >= 1 && row <= 5)
            return LANE_RIVER;
        else if (row >= 7 && row <= 12)
            return LANE_ROAD;
        else
            return LANE_FIXED;
    endfunction

    // Step period multiplier: a lane steps every C_TICK_DIV * k clocks.
    function automatic int lane_speed(int row);
        case (row)
            1, 4, 8, 12: return 1;
            2, 7, 10:    return 2;
            3, 9:        return 3;
            5, 11:       return 4;
            default:     return 1;
        endcase
    endfunction

    // River lanes all drift left; road lanes alternate, even rows left.
    function automatic bit lane_dir_left(int row);
        if (lane_kind(row) == LANE_RIVER)
            return 1'b1;
        return (row % 2) == 0;
    endfunction

    // Bit c of the pattern is column c.
    function automatic logic [C_GRID_W-1:0] lane_init(int row);
        case (row)
            1:       return 14'h0E1C;
            2:       return 14'h3107;
            3:       return 14'h1C38;
            4:       return 14'h0783;
            5:       return 14'h30C6;
            7:       return 14'h0411;
            8:       return 14'h1082;
            9:       return 14'h0841;
            10:      return 14'h2208;
            11:      return 14'h0104;
            12:      return 14'h1111;
            default: return '0;
        endcase
    endfunction

endpackage

// File: rtl/frogger_lane_engine_lane_shifter.sv
// rtl/frogger_lane_engine_lane_shifter.sv - one scrolling lane: step divider plus circular rotate register
module lane_shifter #(
    parameter int               WIDTH    = 14,
    parameter int               DIV      = 1,
    parameter bit               DIR_LEFT = 1'b1,
    parameter logic [WIDTH-1:0] INIT     = '0
) (
    input  logic             i_Clk,
    input  logic             i_Rst_n,
    input  logic             i_Active,
    input  logic             i_Reload,
    output logic [WIDTH-1:0] o_Pattern,
    output logic             o_Step
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

    logic [CW-1:0]    div_q, div_d;
    logic [WIDTH-1:0] pat_q, pat_d;

    // Reload wins over a step landing in the same cycle, so no step is reported then.
    assign o_Step    = i_Active && !i_Reload && (div_q == CW'(DIV - 1));
    assign o_Pattern = pat_q;

    // Next-state: reload restores the pattern, a step rotates it circularly, otherwise count.
    always_comb begin
        div_d = div_q;
        pat_d = pat_q;
        if (i_Reload) begin
            div_d = '0;
            pat_d = INIT;
        end else if (o_Step) begin
            div_d = '0;
            if (DIR_LEFT)
                pat_d = {pat_q[0], pat_q[WIDTH-1:1]};
            else
                pat_d = {pat_q[WIDTH-2:0], pat_q[WIDTH-1]};
        end else if (i_Active) begin
            div_d = div_q + 1'b1;
        end
    end

    // Lane state registers, reset to the initial pattern with a cleared divider.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            div_q <= '0;
            pat_q <= INIT;
        end else begin
            div_q <= div_d;
            pat_q <= pat_d;
        end
    end

endmodule

// File: rtl/frogger_lane_engine.sv
// rtl/frogger_lane_engine.sv - lane state owner answering frog and renderer tile lookups
module frogger_lane_engine
    import frogger_pkg::*;
#(
    parameter int C_TICK_DIV_P = C_TICK_DIV
) (
    input  logic       i_Clk,
    input  logic       i_Rst_n,
    input  logic       i_Game_Active,
    input  logic       i_Reload,
    input  logic [5:0] i_Frogger_X,
    input  logic [5:0] i_Frogger_Y,
    input  logic [5:0] i_Col_Count_Div,
    input  logic [5:0] i_Row_Count_Div,
    output logic [3:0] o_Bitmap_Data,
    output logic       o_On_Log,
    output logic       o_Collided,
    output logic [3:0] o_Render_Tile,
    output logic       o_Log_Shift
);

    logic [C_GRID_H-1:0][C_GRID_W-1:0] lane_pat;
    logic [C_GRID_H-1:0]               lane_step;

    logic [3:0] frog_tile_d, render_tile_d;
    logic       shift_d;

    logic [3:0] bitmap_q, render_q;
    logic       on_log_q, collided_q, shift_q;

    genvar r;
    for (r = 0; r < C_GRID_H; r++) begin : g_lane
        if (lane_kind(r) != LANE_FIXED) begin : g_mov
            lane_shifter #(
                .WIDTH    (C_GRID_W),
                .DIV      (C_TICK_DIV_P * lane_speed(r)),
                .DIR_LEFT (lane_dir_left(r)),
                .INIT     (lane_init(r))
            ) u_shift (
                .i_Clk     (i_Clk),
                .i_Rst_n   (i_Rst_n),
                .i_Active  (i_Game_Active),
                .i_Reload  (i_Reload),
                .o_Pattern (lane_pat[r]),
                .o_Step    (lane_step[r])
            );
        end else begin : g_fix
            assign lane_pat[r]  = '0;
            assign lane_step[r] = 1'b0;
        end
    end

    function automatic logic [3:0] tile_at(
        input logic [5:0]                        x,
        input logic [5:0]                        y,
        input logic [C_GRID_H-1:0][C_GRID_W-1:0] pats
    );
        logic occ;
        tile_at = TILE_OUT;
        if (x < 6'(C_GRID_W) && y < 6'(C_GRID_H)) begin
            occ = pats[y[3:0]][x[3:0]];
            if (y == 6'd0)
                tile_at = C_LILY_MASK[x[3:0]] ? TILE_LILY : TILE_GRASS;
            else if (lane_kind(int'(y)) == LANE_RIVER)
                tile_at = occ ? TILE_LOG : TILE_WATER;
            else if (lane_kind(int'(y)) == LANE_ROAD)
                tile_at = occ ? TILE_CAR : TILE_ROAD;
            else
                tile_at = TILE_GRASS;
        end
    endfunction

    // Both lookup ports see the pre-rotation pattern of the current cycle.
    always_comb begin
        frog_tile_d   = tile_at(i_Frogger_X, i_Frogger_Y, lane_pat);
        render_tile_d = tile_at(i_Col_Count_Div, i_Row_Count_Div, lane_pat);
        shift_d       = 1'b0;
        if (i_Frogger_Y >= 6'd1 && i_Frogger_Y <= 6'd5)
            shift_d = lane_step[i_Frogger_Y[3:0]];
    end

    // One-cycle lookup latency; LOG and CAR only exist in river and road rows respectively.
    always_ff @(posedge i_Clk or negedge i_Rst_n) begin
        if (!i_Rst_n) begin
            bitmap_q   <= TILE_OUT;
            on_log_q   <= 1'b0;
            collided_q <= 1'b0;
            render_q   <= TILE_OUT;
            shift_q    <= 1'b0;
        end else begin
            bitmap_q   <= frog_tile_d;
            on_log_q   <= (frog_tile_d == TILE_LOG);
            collided_q <= (frog_tile_d == TILE_CAR);
            render_q   <= render_tile_d;
            shift_q    <= shift_d;
        end
    end

    assign o_Bitmap_Data = bitmap_q;
    assign o_On_Log      = on_log_q;
    assign o_Collided    = collided_q;
    assign o_Render_Tile = render_q;
    assign o_Log_Shift   = shift_q;

endmodule

// File: tb/tb_frogger_lane_engine.sv
// tb/tb_frogger_lane_engine.sv - randomized scoreboard bench for frogger_lane_engine
module tb_frogger_lane_engine;

    localparam int TDIV = 3;
    localparam int W    = 14;
    localparam int H    = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       active = 1'b0;
    logic       reload = 1'b0;
    logic [5:0] fx = '0, fy = '0, cx = '0, cy = '0;
    logic [3:0] bm, rt;
    logic       ol, co, ls;

    typedef struct {
        logic [3:0] bm;
        logic       ol;
        logic       co;
        logic [3:0] rt;
        logic       ls;
    } exp_t;

    exp_t sb[$];
    exp_t mon_e;
    int   n_vec = 0;
    int   n_bad = 0;

    int lane [H][W];
    int cnt  [H];

    frogger_lane_engine #(.C_TICK_DIV_P(TDIV)) dut (
        .i_Clk           (clk),
        .i_Rst_n         (rst_n),
        .i_Game_Active   (active),
        .i_Reload        (reload),
        .i_Frogger_X     (fx),
        .i_Frogger_Y     (fy),
        .i_Col_Count_Div (cx),
        .i_Row_Count_Div (cy),
        .o_Bitmap_Data   (bm),
        .o_On_Log        (ol),
        .o_Collided      (co),
        .o_Render_Tile   (rt),
        .o_Log_Shift     (ls)
    );

    always #5 clk = ~clk;

    // 0 fixed, 1 river, 2 road
    function automatic int kind(int row);
        if (row >= 1 && row <= 5) return 1;
        if (row >= 7 && row <= 12) return 2;
        return 0;
    endfunction

    function automatic int speed(int row);
        case (row)
            1, 4, 8, 12: return 1;
            2, 7, 10:    return 2;
            3, 9:        return 3;
            default:     return 4;
        endcase
    endfunction

    function automatic int init_bits(int row);
        case (row)
            1:  return 'h0E1C;
            2:  return 'h3107;
            3:  return 'h1C38;
            4:  return 'h0783;
            5:  return 'h30C6;
            7:  return 'h0411;
            8:  return 'h1082;
            9:  return 'h0841;
            10: return 'h2208;
            11: return 'h0104;
            12: return 'h1111;
            default: return 0;
        endcase
    endfunction

    task automatic model_reset();
        for (int rr = 0; rr < H; rr++) begin
            cnt[rr] = 0;
            for (int c = 0; c < W; c++)
                lane[rr][c] = (init_bits(rr) >> c) & 1;
        end
    endtask

    function automatic int tile(int x, int y);
        if (x >= W || y >= H) return 0;
        if (y == 0) return (x % 3 == 1) ? 4 : 1;
        if (kind(y) == 1) return lane[y][x] ? 3 : 2;
        if (kind(y) == 2) return lane[y][x] ? 6 : 5;
        return 1;
    endfunction

    task automatic model_tick(bit act, bit rl);
        int tmp;
        if (rl) begin
            model_reset();
        end else if (act) begin
            for (int rr = 0; rr < H; rr++) begin
                if (kind(rr) == 0) continue;
                if (cnt[rr] == speed(rr) * TDIV - 1) begin
                    cnt[rr] = 0;
                    if (kind(rr) == 1 || rr % 2 == 0) begin
                        tmp = lane[rr][0];
                        for (int c = 0; c < W - 1; c++) lane[rr][c] = lane[rr][c+1];
                        lane[rr][W-1] = tmp;
                    end else begin
                        tmp = lane[rr][W-1];
                        for (int c = W - 1; c > 0; c--) lane[rr][c] = lane[rr][c-1];
                        lane[rr][0] = tmp;
                    end
                end else begin
                    cnt[rr]++;
                end
            end
        end
    endtask

    task automatic drive(bit act, bit rl, int x, int y, int c, int rr);
        exp_t e;
        int   t;
        @(negedge clk);
        active = act;
        reload = rl;
        fx = 6'(x);
        fy = 6'(y);
        cx = 6'(c);
        cy = 6'(rr);
        t    = tile(x, y);
        e.bm = 4'(t);
        e.ol = (t == 3);
        e.co = (t == 6);
        e.rt = 4'(tile(c, rr));
        e.ls = act && !rl && y >= 1 && y <= 5 && cnt[y] == speed(y) * TDIV - 1;
        sb.push_back(e);
        model_tick(act, rl);
    endtask

    task automatic drive_rand(int n, int p_active);
        for (int i = 0; i < n; i++)
            drive($urandom_range(0, 99) < p_active, $urandom_range(0, 49) == 0,
                  $urandom_range(0, 15), $urandom_range(0, 16),
                  $urandom_range(0, 15), $urandom_range(0, 16));
    endtask

    task automatic check_zero(string name);
        n_vec++;
        if (bm != 0 || ol || co || rt != 0 || ls) begin
            n_bad++;
            $display("FAIL %s: got bm=%0d ol=%0b co=%0b rt=%0d ls=%0b, required all 0",
                     name, bm, ol, co, rt, ls);
        end
    endtask

    // Monitor: outputs are valid every cycle, compare one entry per clock after the edge.
    always @(posedge clk) begin
        #1;
        if (rst_n && sb.size() > 0) begin
            mon_e = sb.pop_front();
            n_vec++;
            if (bm !== mon_e.bm || ol !== mon_e.ol || co !== mon_e.co ||
                rt !== mon_e.rt || ls !== mon_e.ls) begin
                n_bad++;
                $display("FAIL lookup @%0t: got bm=%0d ol=%0b co=%0b rt=%0d ls=%0b, required bm=%0d ol=%0b co=%0b rt=%0d ls=%0b",
                         $time, bm, ol, co, rt, ls,
                         mon_e.bm, mon_e.ol, mon_e.co, mon_e.rt, mon_e.ls);
            end
        end
    end

    initial begin
        model_reset();
        repeat (2) @(negedge clk);
        check_zero("reset_state");
        #2 rst_n = 1'b1;

        // Home row, out-of-range and river/road probes
        drive(0, 0, 4, 0, 5, 0);
        drive(0, 0, 5, 0, 4, 0);
        drive(0, 0, 14, 3, 2, 15);
        drive(0, 0, 3, 15, 14, 0);
        drive(0, 0, 0, 2, 13, 2);
        drive(0, 0, 1, 8, 6, 13);

        // Ride row 2 through a few steps, then row 8 for collisions
        for (int i = 0; i < 4 * 2 * TDIV; i++) drive(1, 0, i % W, 2, 13, 2);
        for (int i = 0; i < 4 * TDIV; i++)     drive(1, 0, 3, 8, 2, 8);

        drive_rand(400, 90);

        // Freeze long enough to span several periods of every lane
        for (int i = 0; i < 3 * 4 * TDIV; i++)
            drive(0, 0, $urandom_range(0, 13), $urandom_range(1, 5),
                  $urandom_range(0, 13), $urandom_range(0, 14));
        for (int i = 0; i < 5 * TDIV; i++)
            drive(1, 0, $urandom_range(0, 13), 1 + (i % 5), $urandom_range(0, 13), 2);

        // Reload landing on a row-2 step: no strobe, patterns back to initial
        for (int i = 0; i < 60 && cnt[2] != 2 * TDIV - 1; i++) drive(1, 0, 0, 2, 0, 2);
        drive(1, 1, 0, 2, 13, 2);
        for (int i = 0; i < W; i++) drive(0, 0, i, 2, i, 1);

        drive_rand(300, 85);

        // Asynchronous reset in the middle of a cycle
        @(posedge clk);
        #3 rst_n = 1'b0;
        #1 check_zero("async_reset");
        @(negedge clk);
        active = 1'b0;
        reload = 1'b0;
        #1 check_zero("reset_held");
        #1 rst_n = 1'b1;
        model_reset();
        for (int i = 0; i < 2 * TDIV + 2; i++) drive(1, 0, i % W, 1, i % W, 1);

        drive_rand(300, 90);

        repeat (2) @(posedge clk);
        #2;
        n_vec++;
        if (sb.size() != 0) begin
            n_bad++;
            $display("FAIL drain: %0d entries left, required 0", sb.size());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
